// File: rtl/gpmc_bram_pkg.sv
// Purpose: shared widths, owner encoding and issue-FSM states for the GPMC block-RAM arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package gpmc_bram_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 16;

    // Owner tag carried alongside each read so its data is routed back to the right requester
    localparam logic OWN_HOST  = 1'b0;
    localparam logic OWN_LOCAL = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/gpmc_bram_arbiter_rd_tag_pipe.sv
// Purpose: delay line of {valid, owner} read tags that tracks reads in flight through the RAM.
// Latency: DEPTH cycles from load to tag_vld/tag_own.
// Backpressure: none; shifts every cycle, and a synchronous clear drops every tag in flight.
// Ports: clk, rst (sync, active-high); load_vld/load_own tag entering; tag_vld/tag_own tag leaving.
module rd_tag_pipe
    import gpmc_bram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_vld,
    input  logic load_own,
    output logic tag_vld,
    output logic tag_own
);

    logic [DEPTH-1:0] vld_sr;
    logic [DEPTH-1:0] own_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            own_sr <= {DEPTH{OWN_HOST}};
        end else begin
            vld_sr[0] <= load_vld;
            own_sr[0] <= load_own;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                own_sr[i] <= own_sr[i-1];
            end
        end
    end

    assign tag_vld = vld_sr[DEPTH-1];
    assign tag_own = own_sr[DEPTH-1];

endmodule

// File: rtl/gpmc_bram_arbiter.sv
// Purpose: shares one single-port block RAM between a host (GPMC) and a local requester.
// Latency: grant is combinational; the RAM access is registered one edge later; read data returns in N+1+RD_LAT.
// Backpressure: the host has fixed priority, and the local requester wins after MAX_WAIT consecutive denied cycles.
// Ports: GPMC_CLK/GPMC_RST; host h_req/h_wr/h_addr/h_din -> h_gnt/h_rvalid/h_rdata;
//        local l_* mirrors the host port set; RAM side a_ena/a_wr/a_addr/a_din and a_dout.
module gpmc_bram_arbiter
    import gpmc_bram_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              GPMC_CLK,
    input  logic              GPMC_RST,
    input  logic              h_req,
    input  logic              h_wr,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_din,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              l_req,
    input  logic              l_wr,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_din,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              a_ena,
    output logic              a_wr,
    output logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_din,
    input  logic [DATA_W-1:0] a_dout
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    state_t            state;
    state_t            state_nxt;

    logic              gnt_any;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;
    logic              tag_vld;
    logic              tag_own;

    // Arbitration: the host wins unless the local requester has aged out.
    // Grants are held off while reset is asserted.
    always_comb begin
        h_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!GPMC_RST) begin
            if (h_req && l_req) begin
                if (wait_cnt == WAIT_MAX) l_gnt = 1'b1;
                else                      h_gnt = 1'b1;
            end else if (h_req) begin
                h_gnt = 1'b1;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end
        end
    end

    // Count consecutive denied local cycles. The count restarts once local is served or stops asking.
    always_comb begin
        wait_cnt_nxt = '0;
        if (l_req && !l_gnt) begin
            wait_cnt_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
        end
    end

    assign gnt_any  = h_gnt | l_gnt;
    assign sel_wr   = h_gnt ? h_wr   : l_wr;
    assign sel_addr = h_gnt ? h_addr : l_addr;
    assign sel_din  = h_gnt ? h_din  : l_din;

    always_comb begin
        state_nxt = IDLE;
        if (gnt_any) state_nxt = ISSUE;
    end

    always_ff @(posedge GPMC_CLK) begin
        if (GPMC_RST) begin
            state    <= IDLE;
            wait_cnt <= '0;
            a_wr     <= 1'b0;
            a_addr   <= '0;
            a_din    <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (gnt_any) begin
                a_wr   <= sel_wr;
                a_addr <= sel_addr;
                a_din  <= sel_din;
            end else begin
                // Address and data hold, which keeps the RAM inputs quiet between accesses
                a_wr   <= 1'b0;
            end
        end
    end

    // The RAM is enabled exactly in the cycle after each grant
    assign a_ena = (state == ISSUE);

    // The tag enters the pipe on the grant edge. The RAM is accessed one edge later and its data
    // needs RD_LAT more cycles, so a depth of RD_LAT+1 lines the tag up with a_dout.
    rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_rd_tag_pipe (
        .clk      (GPMC_CLK),
        .rst      (GPMC_RST),
        .load_vld (gnt_any && !sel_wr),
        .load_own (l_gnt ? OWN_LOCAL : OWN_HOST),
        .tag_vld  (tag_vld),
        .tag_own  (tag_own)
    );

    assign h_rvalid = tag_vld && (tag_own == OWN_HOST);
    assign l_rvalid = tag_vld && (tag_own == OWN_LOCAL);
    assign h_rdata  = a_dout;
    assign l_rdata  = a_dout;

endmodule

// File: doc/gpmc_bram_arbiter.md
Name: gpmc_bram_arbiter

Overview:
- Shares one 2048x16 single-port block RAM between two requesters.
- Host requester: GPMC-side adapter. Local requester: FPGA fabric logic such as capture or DMA engines.
- Host has fixed priority. An aging counter bounds how long the local requester can starve.
- Drives the RAM's a_ena/a_wr/a_addr/a_din/a_dout port and routes read data back to whichever requester issued the read.

Parameters:
ADDR_W, 11, RAM address width
DATA_W, 16, RAM data width
RD_LAT, 1, RAM read latency in cycles (a_dout valid RD_LAT cycles after the access edge)
MAX_WAIT, 4, consecutive denied local-request cycles before local is forced to win one grant

Ports:
GPMC_CLK  in  1  sole clock
GPMC_RST  in  1  synchronous, active-high reset
h_req  in  1  host access request
h_wr  in  1  host: 1=write, 0=read
h_addr  in  ADDR_W  host address
h_din  in  DATA_W  host write data
h_gnt  out  1  host request accepted this cycle
h_rvalid  out  1  host read data valid
h_rdata  out  DATA_W  host read data
l_req, l_wr, l_addr, l_din  in  1/1/ADDR_W/DATA_W  local request, same meaning as host
l_gnt, l_rvalid, l_rdata  out  1/1/DATA_W  local grant and read return
a_ena  out  1  RAM enable
a_wr  out  1  RAM write enable
a_addr  out  ADDR_W  RAM address
a_din  out  DATA_W  RAM write data
a_dout  in  DATA_W  RAM read data

Behaviour:
- Clock and reset: one clock, GPMC_CLK. Reset GPMC_RST is synchronous and active-high.
- Reset values: a_ena=0, a_wr=0, a_addr=0, a_din=0, wait_cnt=0, read-tag pipe cleared. Therefore h_rvalid=0 and l_rvalid=0 from the first cycle after the reset edge. Grants are 0 while GPMC_RST=1.
- Handshake: a transfer occurs in cycle N when req && gnt. gnt is combinational from the req inputs and wait_cnt.
  - A requester holds req/wr/addr/din stable until gnt.
  - It may drop req without a grant.
- Arbitration (combinational), evaluated each cycle:
  - Only h_req: h_gnt=1.
  - Only l_req: l_gnt=1.
  - Both requesting and wait_cnt<MAX_WAIT: h_gnt=1.
  - Both requesting and wait_cnt==MAX_WAIT: l_gnt=1.
  - h_gnt and l_gnt are never both 1.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - Increments when l_req && !l_gnt; saturates at MAX_WAIT.
  - Clears to 0 on l_gnt or when !l_req.
- Issue FSM, states IDLE and ISSUE (registered):
  - Edge ending cycle N with a grant: a_ena=1, a_wr=granted wr, a_addr/a_din=granted addr/din. State goes to ISSUE.
  - Edge with no grant: a_ena=0, a_wr=0, a_addr/a_din hold. State goes to IDLE.
  - Back-to-back grants keep ISSUE. Throughput is one access per cycle with no bubbles.
- Read return:
  - Read tag pipeline {valid, owner} has depth RD_LAT+1 and is loaded on each read grant. Writes load valid=0.
  - A read granted in cycle N asserts <owner>_rvalid in cycle N+1+RD_LAT (N+2 by default). In that cycle <owner>_rdata = a_dout (combinational pass-through).
  - When not valid, rdata still mirrors a_dout and has no meaning.
  - The non-owner's rvalid stays 0.
- Read-after-write to the same address in consecutive grants returns the new data (RAM write-first). The arbiter does not forward data.
- Reset mid-operation: in-flight reads are discarded and no rvalid fires for them. A request held across reset release is granted normally afterwards.
- Address width: a_addr carries exactly ADDR_W bits; there is no truncation or extension internally.

Decomposition:
- Package gpmc_bram_pkg holds:
  - ADDR_W and DATA_W defaults
  - owner encoding constant (OWN_HOST=0, OWN_LOCAL=1)
  - FSM state typedef {IDLE, ISSUE}
- One sub-module, rd_tag_pipe: parameterised RD_LAT+1 shift register of {valid, owner} with synchronous clear.

Test Plan:
- Host only:
  - Stimulus: write 0xBEEF to 0x005, then read 0x005.
  - Response: h_gnt both cycles; a_ena/a_wr=1/1 then 1/0; h_rvalid exactly 2 cycles after the read grant with h_rdata=0xBEEF; l_rvalid=0 throughout.
- Contention aging:
  - Stimulus: h_req and l_req held high continuously, MAX_WAIT=4.
  - Response: h_gnt for 4 cycles, then l_gnt for 1 cycle, then the pattern repeats; never both grants high in one cycle.
- Local read routing:
  - Stimulus: preload 0x7FF=0x1234; local reads 0x7FF while the host writes other addresses back-to-back.
  - Response: l_rvalid once with l_rdata=0x1234; h_rvalid stays 0.
- Interleaved reads:
  - Stimulus: host reads 0x010 (data 0xAAAA) in cycle N; local reads 0x020 (data 0x5555) in cycle N+1.
  - Response: h_rvalid@N+2 with 0xAAAA; l_rvalid@N+3 with 0x5555.
- Reset mid-read:
  - Stimulus: host read granted in cycle N; GPMC_RST=1 in cycle N+1.
  - Response: no h_rvalid in N+2; a_ena=0 after the reset edge; wait_cnt=0.
- Back-to-back throughput:
  - Stimulus: 16 consecutive host writes to 0x000–0x00F.
  - Response: a_ena high for 16 consecutive cycles; addresses increment one per cycle; readback of every word matches.
